dmx_frame_sequencer: RTL and testbench
======================================

// Module: dmx_frame_sequencer
// PURPOSE
//  Sequences one DMX512 frame per start: break, mark-after-break (MAB), start code, then N slots
//  read from the universe frame buffer and handed byte-by-byte to the 250 kbaud 8N2 serializer.
//  Sits between the ece453 register block (DMX_SIZE, CONTROL.DMX_START, STATUS, IM) and the
//  frame buffer read port / UART byte interface; raises frame_done for STATUS and the IRQ.
// PARAMETERS
//  BREAK_CYC   5000  break length in clk cycles (100 us @ 50 MHz)
//  MAB_CYC     600   mark-after-break length in clk cycles (12 us @ 50 MHz)
//  MAX_SLOTS   512   largest slot count; buffer address width is 9
// PORTS
//  clk           in   1   system clock
//  reset         in   1   asynchronous, active-low reset
//  start         in   1   1-cycle pulse from CONTROL.DMX_START write
//  abort         in   1   level; stop the frame at the next byte boundary
//  continuous    in   1   level; restart a new frame automatically after frame_done
//  slot_size     in   32  requested slot count (DMX_SIZE register, raw)
//  start_code    in   8   byte sent after MAB (0x00 for dimmer data)
//  buf_rd_en     out  1   frame-buffer read strobe
//  buf_rd_addr   out  9   frame-buffer slot address (0-based)
//  buf_rd_data   in   8   read data, valid exactly 1 cycle after buf_rd_en
//  tx_valid      out  1   byte available to serializer
//  tx_data       out  8   byte to serializer
//  tx_ready      in   1   serializer accepts byte when tx_valid & tx_ready
//  tx_idle       in   1   serializer shift register empty, line at mark
//  break_o       out  1   forces DMX line low (serializer output gated by top level)
//  busy          out  1   frame in progress (STATUS bit 0)
//  frame_done    out  1   1-cycle pulse when last slot accepted or abort completes
//  slot_index    out  10  slots accepted so far in current frame
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; all outputs 0; counters 0; snapshot regs 0.
//  - Slot count snapshot on accepted start: n = (slot_size==0)?1 : min(slot_size, MAX_SLOTS).
//    Later slot_size writes do not affect the frame in progress.
//  - States: IDLE -> WAIT_IDLE -> BREAK -> MAB -> START_CODE -> FETCH -> SEND -> (FETCH | DONE).
//  - IDLE: start=1 -> WAIT_IDLE, busy=1 next cycle. start while busy is ignored (not queued).
//  - WAIT_IDLE: hold until tx_idle=1 (previous frame's last stop bits drained), then BREAK.
//  - BREAK: break_o=1 for exactly BREAK_CYC cycles, then MAB with break_o=0 for MAB_CYC cycles.
//  - START_CODE: tx_valid=1, tx_data=start_code until tx_valid&tx_ready; then FETCH with addr=0.
//  - FETCH: buf_rd_en=1 for one cycle at buf_rd_addr; next cycle latch buf_rd_data into tx_data,
//    enter SEND. FETCH-to-tx_valid latency 2 cycles.
//  - SEND: tx_valid held, tx_data stable until tx_ready; on handshake slot_index+=1,
//    buf_rd_addr+=1; if slot_index reaches n -> DONE, else FETCH.
//  - tx_valid never deasserts without a handshake; tx_data never changes while tx_valid=1.
//  - DONE: frame_done=1 one cycle, busy=0 same cycle; continuous=1 -> WAIT_IDLE (busy=1 next
//    cycle, new snapshot of slot_size), else IDLE. buf_rd_addr, slot_index hold until next start.
//  - abort=1: in WAIT_IDLE/BREAK/MAB -> DONE next cycle (break_o drops immediately); in
//    START_CODE/SEND -> DONE after the pending handshake; in FETCH -> DONE without sending.
//    abort overrides continuous (returns to IDLE).
//  - start and abort same cycle in IDLE: start ignored.
//  - buf_rd_addr never exceeds n-1; no wrap past MAX_SLOTS-1 (511).
//  - Counters sized for max(BREAK_CYC, MAB_CYC); reset mid-frame drops break_o and tx_valid
//    asynchronously.
// TESTING
//  1. start, slot_size=3, buffer {0x11,0x22,0x33}, tx_ready=1 -> break_o high 5000 cyc, low 600,
//     tx bytes 0x00,0x11,0x22,0x33, one frame_done pulse, busy=0, slot_index=3.
//  2. slot_size=0x0022_2222 -> exactly 512 slots sent, last buf_rd_addr=0x1FF, no wrap.
//  3. tx_ready toggled randomly, buffer slot k = k[7:0] -> byte order intact, tx_data stable
//     while tx_valid, no dropped or duplicated slot.
//  4. tx_idle held 0 for 200 cyc after start -> break_o stays 0 until tx_idle=1.
//  5. continuous=1, size 2 -> back-to-back frames, second break only after tx_idle;
//     abort during slot 1 SEND -> slot 1 completes, frame_done, IDLE, no further break.
//  6. reset asserted mid-BREAK and mid-SEND -> all outputs 0 immediately; second start
//     during busy ignored (single frame_done).

Source files
------------

// File: rtl/dmx_frame_sequencer.sv
// Purpose     : sequences one DMX512 frame per start (break, MAB, start code, N buffer slots) into the byte serializer.
// Latency     : start -> busy 1 cycle; FETCH -> tx_valid 2 cycles; final slot handshake -> frame_done 1 cycle.
// Backpressure: tx_valid/tx_data held until tx_ready; the next buffer read is issued only after the current byte is accepted.
module dmx_frame_sequencer #(
    parameter int BREAK_CYC = 5000,
    parameter int MAB_CYC   = 600,
    parameter int MAX_SLOTS = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        continuous,
    input  logic [31:0] slot_size,
    input  logic [7:0]  start_code,
    output logic        buf_rd_en,
    output logic [8:0]  buf_rd_addr,
    input  logic [7:0]  buf_rd_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        tx_idle,
    output logic        break_o,
    output logic        busy,
    output logic        frame_done,
    output logic [9:0]  slot_index
);

    // One down-counter serves both timed line states, so size it for the longer one.
    localparam int CNT_MAX = (BREAK_CYC > MAB_CYC) ? BREAK_CYC : MAB_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // RD_WAIT is the cycle in which the buffer returns data for the read issued in FETCH.
    typedef enum logic [3:0] {
        IDLE,
        WAIT_IDLE,
        BREAK,
        MAB,
        START_CODE,
        FETCH,
        RD_WAIT,
        SEND,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [9:0]    n_slots;
    logic [9:0]    n_req;
    logic [9:0]    slot_next;
    logic          aborted;
    logic          restart;

    // Clamp the raw DMX_SIZE value: zero means one slot, anything above the buffer size saturates.
    always_comb begin
        n_req = 10'(MAX_SLOTS);
        if (slot_size == 32'd0) begin
            n_req = 10'd1;
        end else if (slot_size < 32'(MAX_SLOTS)) begin
            n_req = slot_size[9:0];
        end
    end

    // Slot count after the pending handshake, and whether DONE should launch another frame.
    // An abort (stored or still asserted) always wins over continuous mode.
    always_comb begin
        slot_next = slot_index + 10'd1;
        restart   = (start && !abort) || (continuous && !aborted && !abort);
    end

    // Frame sequencer: every output is a register updated alongside the state transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            n_slots     <= '0;
            aborted     <= 1'b0;
            buf_rd_en   <= 1'b0;
            buf_rd_addr <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            break_o     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            slot_index  <= '0;
        end else begin
            frame_done <= 1'b0;
            buf_rd_en  <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with abort is dropped.
                    if (start && !abort) begin
                        state       <= WAIT_IDLE;
                        busy        <= 1'b1;
                        n_slots     <= n_req;
                        slot_index  <= '0;
                        buf_rd_addr <= '0;
                        aborted     <= 1'b0;
                    end
                end
                WAIT_IDLE: begin
                    // Let the previous frame's stop bits drain before pulling the line low.
                    if (abort) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        aborted    <= 1'b1;
                    end else if (tx_idle) begin
                        state   <= BREAK;
                        break_o <= 1'b1;
                        cnt     <= CW'(BREAK_CYC - 1);
                    end
                end
                BREAK: begin
                    if (abort) begin
                        state      <= DONE;
                        break_o    <= 1'b0;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        aborted    <= 1'b1;
                    end else if (cnt == '0) begin
                        state   <= MAB;
                        break_o <= 1'b0;
                        cnt     <= CW'(MAB_CYC - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MAB: begin
                    if (abort) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        aborted    <= 1'b1;
                    end else if (cnt == '0) begin
                        state    <= START_CODE;
                        tx_valid <= 1'b1;
                        tx_data  <= start_code;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                START_CODE: begin
                    // An offered byte is never withdrawn; abort is honoured only at the handshake.
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (abort) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            aborted    <= 1'b1;
                        end else begin
                            state     <= FETCH;
                            buf_rd_en <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    // The read strobe is already out this cycle; abort discards the slot unsent.
                    if (abort) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        aborted    <= 1'b1;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (abort) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        aborted    <= 1'b1;
                    end else begin
                        state    <= SEND;
                        tx_valid <= 1'b1;
                        tx_data  <= buf_rd_data;
                    end
                end
                SEND: begin
                    // The address only advances when another slot follows, so it stops at n-1.
                    if (tx_ready) begin
                        tx_valid   <= 1'b0;
                        slot_index <= slot_next;
                        if (slot_next == n_slots || abort) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            aborted    <= abort;
                        end else begin
                            state       <= FETCH;
                            buf_rd_en   <= 1'b1;
                            buf_rd_addr <= buf_rd_addr + 9'd1;
                        end
                    end
                end
                DONE: begin
                    // A fresh snapshot of slot_size is taken for every new frame.
                    if (restart) begin
                        state       <= WAIT_IDLE;
                        busy        <= 1'b1;
                        n_slots     <= n_req;
                        slot_index  <= '0;
                        buf_rd_addr <= '0;
                        aborted     <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmx_frame_sequencer.sv
// Purpose     : directed bench for dmx_frame_sequencer with a byte scoreboard and line-timing monitor.
// Latency     : expected bytes are queued before each start and popped on every tx handshake.
// Backpressure: tx_ready is driven either at a fixed level or randomly each cycle.
module tb_dmx_frame_sequencer;

    localparam int BREAK_CYC = 5000;
    localparam int MAB_CYC   = 600;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        start      = 1'b0;
    logic        abort      = 1'b0;
    logic        continuous = 1'b0;
    logic [31:0] slot_size  = 32'd0;
    logic [7:0]  start_code = 8'd0;
    logic        buf_rd_en;
    logic [8:0]  buf_rd_addr;
    logic [7:0]  buf_rd_data = 8'd0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready   = 1'b1;
    logic        tx_idle    = 1'b1;
    logic        break_o;
    logic        busy;
    logic        frame_done;
    logic [9:0]  slot_index;

    int          tests    = 0;
    int          fails    = 0;
    logic [7:0]  mem [512];
    logic [7:0]  exp_q [$];
    logic        rnd_ready = 1'b0;
    logic        ready_lvl = 1'b1;
    int          done_cnt = 0;
    int          brk_run  = 0;
    int          last_brk = 0;
    int          mab_run  = 0;
    int          last_mab = 0;
    int          max_addr = 0;
    logic        in_mab   = 1'b0;
    logic        prev_wait = 1'b0;
    logic [7:0]  prev_dat = 8'd0;
    logic [7:0]  mon_exp  = 8'd0;

    dmx_frame_sequencer #(
        .BREAK_CYC (BREAK_CYC),
        .MAB_CYC   (MAB_CYC),
        .MAX_SLOTS (512)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .continuous  (continuous),
        .slot_size   (slot_size),
        .start_code  (start_code),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_idle     (tx_idle),
        .break_o     (break_o),
        .busy        (busy),
        .frame_done  (frame_done),
        .slot_index  (slot_index)
    );

    always #5 clk = ~clk;

    // Frame buffer model: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
    end

    // Serializer ready, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
    end

    // Monitor: scoreboard on handshakes, hold rules, pulse counting and line timing.
    always @(negedge clk) begin
        if (!reset) begin
            prev_wait = 1'b0;
            brk_run   = 0;
            in_mab    = 1'b0;
        end else begin
            if (prev_wait) begin
                tests++;
                assert (tx_valid === 1'b1 && tx_data === prev_dat) else begin
                    fails++;
                    $error("FAIL tx_hold: observed vld=%0b dat=0x%0h expected vld=1 dat=0x%0h", tx_valid, tx_data, prev_dat);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL tx_extra: observed byte 0x%0h expected none", tx_data);
                end
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    tests++;
                    assert (tx_data === mon_exp) else begin
                        fails++;
                        $error("FAIL tx_byte: observed 0x%0h expected 0x%0h", tx_data, mon_exp);
                    end
                end
            end
            prev_wait = tx_valid && !tx_ready;
            prev_dat  = tx_data;
            if (frame_done === 1'b1) done_cnt++;
            if (buf_rd_en === 1'b1 && int'(buf_rd_addr) > max_addr) max_addr = int'(buf_rd_addr);
            if (break_o === 1'b1) begin
                brk_run++;
            end else if (brk_run > 0) begin
                last_brk = brk_run;
                brk_run  = 0;
                in_mab   = 1'b1;
                mab_run  = 0;
            end
            if (in_mab) begin
                if (tx_valid === 1'b1) begin
                    last_mab = mab_run;
                    in_mab   = 1'b0;
                end else if (frame_done === 1'b1) begin
                    in_mab = 1'b0;
                end else begin
                    mab_run++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Returns on the falling edge where frame_done is high, or flags a timeout.
    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(frame_done), 32'd1);
    endtask

    initial begin
        int k;
        int d0;
        logic seen;

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;

        // Reset state
        reset = 1'b0;
        tick(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_break", 32'(break_o), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_rd_en", 32'(buf_rd_en), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_slot_index", 32'(slot_index), 32'd0);
        chk("rst_addr", 32'(buf_rd_addr), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        reset = 1'b1;
        tick(2);

        // 1: three slots, ready always high
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        slot_size = 32'd3; start_code = 8'h00;
        exp_q.push_back(8'h00); exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        d0 = done_cnt;
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1_done", 8000);
        chk("t1_busy_at_done", 32'(busy), 32'd0);
        chk("t1_slot_index", 32'(slot_index), 32'd3);
        chk("t1_last_addr", 32'(buf_rd_addr), 32'd2);
        tick(3);
        chk("t1_break_len", 32'(last_brk), 32'(BREAK_CYC));
        chk("t1_mab_len", 32'(last_mab), 32'(MAB_CYC));
        chk("t1_queue_left", 32'(exp_q.size()), 32'd0);
        chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // 2: oversize request clamps to 512 slots
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
        slot_size = 32'h0022_2222; start_code = 8'hCC;
        exp_q.push_back(8'hCC);
        for (int i = 0; i < 512; i++) exp_q.push_back(mem[i]);
        max_addr = 0;
        pulse_start();
        wait_done("t2_done", 10000);
        chk("t2_slot_index", 32'(slot_index), 32'd512);
        chk("t2_last_addr", 32'(buf_rd_addr), 32'h1FF);
        chk("t2_max_addr", 32'(max_addr), 32'h1FF);
        tick(2);
        chk("t2_queue_left", 32'(exp_q.size()), 32'd0);

        // 3: random backpressure, slot k holds k
        for (int i = 0; i < 512; i++) mem[i] = 8'(i);
        slot_size = 32'd40; start_code = 8'h00;
        exp_q.push_back(8'h00);
        for (int i = 0; i < 40; i++) exp_q.push_back(mem[i]);
        rnd_ready = 1'b1;
        pulse_start();
        wait_done("t3_done", 9000);
        rnd_ready = 1'b0;
        chk("t3_slot_index", 32'(slot_index), 32'd40);
        tick(2);
        chk("t3_queue_left", 32'(exp_q.size()), 32'd0);

        // 4: break waits for the serializer to go idle
        mem[0] = 8'hA5;
        slot_size = 32'd1; start_code = 8'h17;
        exp_q.push_back(8'h17); exp_q.push_back(8'hA5);
        tx_idle = 1'b0;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (break_o !== 1'b0) seen = 1'b1;
        end
        chk("t4_no_break", 32'(seen), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        tick(1);
        tx_idle = 1'b1;
        tick(1);
        chk("t4_break_up", 32'(break_o), 32'd1);
        wait_done("t4_done", 7000);
        tick(2);
        chk("t4_break_len", 32'(last_brk), 32'(BREAK_CYC));
        chk("t4_queue_left", 32'(exp_q.size()), 32'd0);

        // 5: continuous frames, second waits for idle, abort ends the run
        mem[0] = 8'hC1; mem[1] = 8'hC2; mem[2] = 8'hC3;
        slot_size = 32'd2; start_code = 8'h00; continuous = 1'b1;
        exp_q.push_back(8'h00); exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
        exp_q.push_back(8'h00); exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
        d0 = done_cnt;
        pulse_start();
        slot_size = 32'd3;
        wait_done("t5_done1", 8000);
        tx_idle = 1'b0;
        chk("t5_slot_index1", 32'(slot_index), 32'd2);
        chk("t5_busy_gap", 32'(busy), 32'd0);
        tick(1);
        chk("t5_rebusy", 32'(busy), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (break_o !== 1'b0) seen = 1'b1;
        end
        chk("t5_no_break_busy_line", 32'(seen), 32'd0);
        tick(1);
        tx_idle = 1'b1;
        k = 0;
        @(negedge clk);
        while (!(tx_valid === 1'b1 && slot_index == 10'd1) && k < 8000) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reach_slot1", 32'(slot_index), 32'd1);
        abort = 1'b1;
        wait_done("t5_done2", 10);
        abort = 1'b0;
        chk("t5_slot_index2", 32'(slot_index), 32'd2);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (break_o !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        chk("t5_no_restart", 32'(seen), 32'd0);
        chk("t5_done_pulses", 32'(done_cnt - d0), 32'd2);
        chk("t5_queue_left", 32'(exp_q.size()), 32'd0);
        continuous = 1'b0;
        tick(1);

        // 6a: reset in the middle of the break
        slot_size = 32'd1; mem[0] = 8'h3C;
        pulse_start();
        k = 0;
        while (break_o !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t6_break_up", 32'(break_o), 32'd1);
        repeat (100) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_rst_break", 32'(break_o), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        tick(3);
        reset = 1'b1;
        tick(2);

        // 6b: reset while a slot is stalled in SEND
        slot_size = 32'd2; start_code = 8'h99; mem[0] = 8'h3C; mem[1] = 8'h4D;
        exp_q.push_back(8'h99); exp_q.push_back(8'h3C);
        ready_lvl = 1'b1;
        pulse_start();
        k = 0;
        @(negedge clk);
        while (buf_rd_en !== 1'b1 && k < 7000) begin
            @(negedge clk);
            k++;
        end
        chk("t6_fetch_seen", 32'(buf_rd_en), 32'd1);
        ready_lvl = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_send_valid", 32'(tx_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("t6_rst_busy2", 32'(busy), 32'd0);
        chk("t6_rst_tx_data", 32'(tx_data), 32'd0);
        chk("t6_rst_slot_index", 32'(slot_index), 32'd0);
        chk("t6_unsent", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        ready_lvl = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(2);

        // 6c: a second start during busy is not queued
        slot_size = 32'd1; start_code = 8'h55; mem[0] = 8'h66;
        exp_q.push_back(8'h55); exp_q.push_back(8'h66);
        d0 = done_cnt;
        pulse_start();
        tick(10);
        pulse_start();
        wait_done("t6_done", 8000);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (break_o !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        chk("t6_no_second_frame", 32'(seen), 32'd0);
        chk("t6_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t6_queue_left", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
